// File: rtl/brick_ram_arbiter.sv
// Brick-map RAM owner: arbitrates loader writes, video reads and collision read-clear RMW,
// and tracks the live brick count. Optional macro COL_STARVE_GUARD_EN adds a collision starvation guard.
module brick_ram_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_active,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  output logic              col_gnt,
  output logic              col_done,
  output logic              col_hit,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   brick_cnt,
  output logic              all_clear
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WB = 2'd2} state_t;

  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   col_addr_q;
  logic                rd_vid_q;
  logic [DATA_W-1:0]   vid_hold_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                all_clear_q;
  logic                hit, gnt_wb, gnt_ld, gnt_vid, gnt_col, col_ok, col_pri;

`ifdef COL_STARVE_GUARD_EN
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] wait_q;

  // Load windows pause the count rather than restarting it.
  always_ff @(posedge clk or negedge rst)
    if (!rst)                                   wait_q <= '0;
    else if (!col_req || gnt_col)               wait_q <= '0;
    else if (!ld_active && wait_q != WAIT_TOP)  wait_q <= wait_q + 1'b1;

  assign col_pri = (wait_q == WAIT_TOP);
`else
  assign col_pri = 1'b0;
`endif

  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    hit      = (state_q == RD) && (ram_rdata != '0);
    gnt_wb   = rst && hit;
    gnt_ld   = rst && !gnt_wb && ld_active && ld_valid;
    col_ok   = rst && col_req && !ld_active && (state_q != RD);
    gnt_vid  = rst && !gnt_wb && !gnt_ld && vid_req && !(col_ok && col_pri);
    gnt_col  = col_ok && !gnt_vid;

    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (gnt_wb) begin
      ram_addr = col_addr_q;
      ram_we   = 1'b1;
    end else if (gnt_ld) begin
      ram_addr  = ld_addr;
      ram_we    = 1'b1;
      ram_wdata = ld_data;
    end else if (gnt_vid) begin
      ram_addr = vid_addr;
    end else if (gnt_col) begin
      ram_addr = col_addr;
    end
  end

  // WB is a tail state only; the clear itself is issued from RD, so a new read may start here.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WB: state_d = gnt_col ? RD : IDLE;
      RD:       state_d = hit ? WB : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_addr_q  <= '0;
      rd_vid_q    <= 1'b0;
      vid_hold_q  <= '0;
      cnt_q       <= '0;
      all_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_vid_q    <= gnt_vid;
      vid_hold_q  <= vid_rdata;
      if (gnt_col) col_addr_q <= col_addr;
      all_clear_q <= gnt_wb && !ld_start && (cnt_q == CNT_W'(1));
      if (ld_start)
        cnt_q <= '0;
      else if (gnt_ld && ld_data != '0 && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
      else if (gnt_wb && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  assign ld_ready   = gnt_ld;
  assign col_gnt    = gnt_col;
  assign col_done   = (state_q == RD);
  assign col_hit    = hit;
  assign vid_rvalid = rd_vid_q;
  assign vid_rdata  = rd_vid_q ? ram_rdata : vid_hold_q;
  assign brick_cnt  = cnt_q;
  assign all_clear  = all_clear_q;

endmodule

// File: tb/tb_brick_ram_arbiter.sv
// Directed-random bench for brick_ram_arbiter: behavioural RAM, shadow brick map and brick count.
module tb_brick_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 2;
  localparam int MW = 8;
  localparam int N  = 64;

  logic          clk, rst;
  logic          ld_start, ld_active, ld_valid, ld_ready;
  logic [AW-1:0] ld_addr, vid_addr, col_addr, ram_addr;
  logic [DW-1:0] ld_data, vid_rdata, ram_wdata, ram_rdata;
  logic          vid_req, vid_rvalid, col_req, col_gnt, col_done, col_hit, ram_we, all_clear;
  logic [AW:0]   brick_cnt;

  brick_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_active(ld_active), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready), .vid_req(vid_req),
    .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata), .col_req(col_req),
    .col_addr(col_addr), .col_gnt(col_gnt), .col_done(col_done), .col_hit(col_hit),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .brick_cnt(brick_cnt), .all_clear(all_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous RAM, 1-cycle read latency
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int            vectors = 0;
  int            errs    = 0;
  logic [DW-1:0] shadow [N];
  int            exp_cnt;
  logic [DW-1:0] last_vid;
  logic          guard;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_begin();
    ld_start = 1'b1; ld_active = 1'b1; ld_valid = 1'b0; vid_req = 1'b0;
    @(negedge clk);
    chk("ld_start_no_clear", all_clear, 0);
    exp_cnt = 0;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic ld_cell(input int a, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_addr = AW'(a); ld_data = d;
    vid_req  = 1'($urandom_range(0, 1)); vid_addr = AW'($urandom_range(0, N-1));
    @(negedge clk);
    chk("ld_ready", ld_ready, 1);
    chk("ld_we", ram_we, 1);
    chk("ld_addr", ram_addr, a);
    chk("ld_vid_denied", vid_rvalid, 0);
    chk("ld_all_clear", all_clear, 0);
    shadow[a] = d;
    if (d != '0 && exp_cnt < N) exp_cnt++;
    tick();
  endtask

  task automatic load_end();
    ld_active = 1'b0; ld_valid = 1'b0; vid_req = 1'b0;
    @(negedge clk);
    chk("load_cnt", brick_cnt, exp_cnt);
    chk("load_vid_denied", vid_rvalid, 0);
    tick();
  endtask

  task automatic vid_stream(input int n);
    logic pv;
    int   pa;
    pv = 1'b0; pa = 0;
    for (int k = 0; k <= n; k++) begin
      vid_req  = (k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      vid_addr = AW'($urandom_range(0, N-1));
      @(negedge clk);
      chk("vid_rvalid", vid_rvalid, pv);
      if (pv) begin
        chk("vid_rdata", vid_rdata, shadow[pa]);
        last_vid = shadow[pa];
      end else begin
        chk("vid_hold", vid_rdata, last_vid);
      end
      chk("vid_no_we", ram_we, 0);
      pv = vid_req; pa = int'(vid_addr);
      tick();
    end
  endtask

  // One collision RMW; optional video request, held col_req and ld_start in the result cycle
  task automatic col_op(input int a, input logic vid_n1, input logic hold_n1, input logic lds_n1);
    int   w;
    int   va;
    logic h, clr, vexp;
    col_req = 1'b1; col_addr = AW'(a); vid_req = 1'b0;
    w = 0;
    @(negedge clk);
    while (!col_gnt && w < 20) begin
      tick();
      @(negedge clk);
      w++;
    end
    chk("col_gnt", col_gnt, 1);
    chk("col_rd_addr", ram_addr, a);
    chk("col_rd_we", ram_we, 0);
    tick();
    h = (shadow[a] != '0);
    col_req = hold_n1; vid_req = vid_n1; ld_start = lds_n1;
    vid_addr = AW'($urandom_range(0, N-1)); va = int'(vid_addr);
    @(negedge clk);
    chk("col_done", col_done, 1);
    chk("col_hit", col_hit, h);
    chk("col_wb_we", ram_we, h);
    chk("col_busy_no_gnt", col_gnt, 0);
    if (h) begin
      chk("col_wb_addr", ram_addr, a);
      chk("col_wb_data", ram_wdata, 0);
    end
    tick();
    clr = 1'b0;
    if (lds_n1) exp_cnt = 0;
    else if (h && exp_cnt > 0) begin
      exp_cnt--;
      clr = (exp_cnt == 0);
    end
    if (h) shadow[a] = '0;
    col_req = 1'b0; vid_req = 1'b0; ld_start = 1'b0;
    @(negedge clk);
    chk("col_cnt", brick_cnt, exp_cnt);
    chk("all_clear", all_clear, clr);
    chk("col_done_end", col_done, 0);
    vexp = vid_n1 && !h;
    chk("wb_vid_rvalid", vid_rvalid, vexp);
    if (vexp) begin
      chk("rmw_vid_rdata", vid_rdata, shadow[va]);
      last_vid = shadow[va];
    end else begin
      chk("wb_vid_hold", vid_rdata, last_vid);
    end
    tick();
    @(negedge clk);
    chk("all_clear_pulse", all_clear, 0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic          granted, g_prev, tail_g, eg;
    logic [DW-1:0] d;
    int            pa;
`ifdef COL_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    // Reset with every requester active: outputs must still be 0
    rst = 1'b0; ld_start = 1'b0; ld_active = 1'b1; ld_valid = 1'b1; ld_addr = 3; ld_data = 1;
    vid_req = 1'b1; vid_addr = 5; col_req = 1'b1; col_addr = 9;
    exp_cnt = 0; last_vid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_col_gnt", col_gnt, 0);
    chk("rst_col_done", col_done, 0);
    chk("rst_vid_rvalid", vid_rvalid, 0);
    chk("rst_cnt", brick_cnt, 0);
    chk("rst_all_clear", all_clear, 0);
    ld_active = 1'b0; ld_valid = 1'b0; vid_req = 1'b0; col_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Small load: 5 cells, 3 bricks
    load_begin();
    ld_cell(0, 2'd1); ld_cell(1, 2'd0); ld_cell(2, 2'd2); ld_cell(3, 2'd0); ld_cell(4, 2'd3);
    load_end();

    // Full random level; cell 7 = 2, cell 8 empty
    load_begin();
    for (int i = 0; i < N; i++) begin
      d = (i == 7) ? 2'd2 : (i == 8) ? 2'd0 : DW'($urandom_range(0, 3));
      ld_cell(i, d);
    end
    load_end();

    vid_stream(24);
    col_op(7, 1'b0, 1'b0, 1'b0);
    col_op(8, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++)
      col_op($urandom_range(0, N-1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    vid_stream(12);

    // Destroy every remaining brick; the last one raises all_clear
    for (int a = 0; a < N; a++)
      if (shadow[a] != '0) col_op(a, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("cleared_cnt", brick_cnt, 0);

    // ld_start beats a decrement, then a hit at count 0 does not wrap
    load_begin();
    ld_cell(30, 2'd2); ld_cell(31, 2'd1);
    load_end();
    col_op(30, 1'b0, 1'b0, 1'b1);
    col_op(31, 1'b0, 1'b0, 1'b0);

    // Contention: video every cycle against a pending collision
    granted = 1'b0; g_prev = 1'b0; pa = 0;
    for (int k = 0; k < 12; k++) begin
      vid_req = 1'b1; vid_addr = AW'($urandom_range(0, N-1));
      col_req = !granted; col_addr = 12;
      @(negedge clk);
      eg = guard && (k == MW);
      chk("contend_col_gnt", col_gnt, eg);
      if (k > 0) begin
        chk("contend_vid_rvalid", vid_rvalid, !g_prev);
        if (!g_prev) chk("contend_vid_rdata", vid_rdata, shadow[pa]);
      end
      chk("contend_col_done", col_done, g_prev);
      g_prev = col_gnt;
      if (col_gnt) granted = 1'b1;
      pa = int'(vid_addr);
      tick();
    end
    vid_req = 1'b0; col_req = !granted;
    @(negedge clk);
    tail_g = !granted;
    chk("tail_vid_rvalid", vid_rvalid, 1);
    chk("tail_vid_rdata", vid_rdata, shadow[pa]);
    last_vid = shadow[pa];
    chk("tail_col_gnt", col_gnt, tail_g);
    tick();
    col_req = 1'b0;
    @(negedge clk);
    chk("tail_col_done", col_done, tail_g);
    chk("tail_col_hit", col_hit, 0);
    tick();

    // Reset in the result cycle of a hit: no write-back
    load_begin();
    ld_cell(40, 2'd3);
    load_end();
    col_req = 1'b1; col_addr = 40;
    @(negedge clk);
    chk("rmw_rst_gnt", col_gnt, 1);
    tick();
    col_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rmw_rst_we", ram_we, 0);
    chk("rmw_rst_done", col_done, 0);
    chk("rmw_rst_hit", col_hit, 0);
    chk("rmw_rst_cnt", brick_cnt, 0);
    chk("rmw_rst_all_clear", all_clear, 0);
    chk("rmw_rst_vid", vid_rvalid, 0);
    tick();
    rst = 1'b1; exp_cnt = 0; last_vid = '0;
    tick();
    vid_req = 1'b1; vid_addr = 40;
    @(negedge clk);
    tick();
    vid_req = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", vid_rvalid, 1);
    chk("post_rst_cell", vid_rdata, shadow[40]);
    chk("post_rst_cnt", brick_cnt, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
